// File: rtl/dmi_jtag_master.sv
// JTAG probe-side initiator: turns valid/ready scan commands into TCK/TMS/TDI slot sequences
// and returns the captured TDO bits. Every transaction starts and ends in Run-Test/Idle.
module dmi_jtag_master #(
    parameter int unsigned MaxLen      = 41,
    parameter int unsigned IrLength    = 5,
    parameter int unsigned ClkDiv      = 2,
    parameter int unsigned ResetCycles = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_op_i,
    input  logic [$clog2(MaxLen+1)-1:0]  req_len_i,
    input  logic [MaxLen-1:0]            req_data_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [MaxLen-1:0]            rsp_data_o,
    output logic                         busy_o,
    output logic                         tck_o,
    output logic                         tms_o,
    output logic                         tdi_o,
    input  logic                         tdo_i
);
    localparam int unsigned LenW     = $clog2(MaxLen + 1);
    localparam int unsigned ShiftMax = (MaxLen > IrLength) ? MaxLen : IrLength;
    localparam int unsigned BitW     = $clog2(ShiftMax);
    localparam int unsigned SlotMax  = (ShiftMax + 6 > ResetCycles + 1) ? ShiftMax + 6
                                                                        : ResetCycles + 1;
    localparam int unsigned SlotW    = $clog2(SlotMax);
    localparam int unsigned CycW     = $clog2(2 * ClkDiv);

    typedef enum logic [2:0] {StPostReset, StIdle, StReset, StIrScan, StDrScan, StResp} state_e;

    state_e              state_q;
    logic [CycW-1:0]     cyc_q;
    logic [SlotW-1:0]    slot_q;
    logic [BitW-1:0]     bit_q;
    logic [LenW-1:0]     len_q;
    logic [MaxLen-1:0]   data_q;
    logic [MaxLen-1:0]   rsp_data_q;
    logic                shift_q, rsp_valid_q, req_ready_q, busy_q, tck_q, tms_q, tdi_q;

    state_e              plan_st;
    logic [SlotW-1:0]    plan_slot;
    logic [LenW-1:0]     plan_len;
    logic [MaxLen-1:0]   plan_data;
    logic [BitW-1:0]     plan_bit;
    logic                plan_tms, plan_shift, plan_tdi, slot_last;

    // Index of the final slot of an op; DR with N=0 still takes 5 slots (N+5 with N=0).
    function automatic logic [SlotW-1:0] last_slot(state_e st, logic [LenW-1:0] n);
        int unsigned last;
        case (st)
            StIrScan: last = IrLength + 5;
            StDrScan: last = 32'(n) + 4;
            default:  last = ResetCycles;
        endcase
        return SlotW'(last);
    endfunction

    assign slot_last = (slot_q == last_slot(state_q, len_q));

    // Pin values for the slot about to start: slot 0 of a new op when Idle, else the next slot.
    always_comb begin : plan_comb
        int unsigned s;
        int unsigned n;
        plan_st   = state_q;
        plan_slot = slot_q + SlotW'(1);
        plan_len  = len_q;
        plan_data = data_q;
        if (state_q == StIdle) begin
            plan_slot = '0;
            plan_len  = (req_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : req_len_i;
            plan_data = req_data_i;
            unique case (req_op_i)
                2'd0:    plan_st = StReset;
                2'd1:    plan_st = StIrScan;
                2'd2:    plan_st = StDrScan;
                default: plan_st = StResp;
            endcase
        end
        s          = 32'(plan_slot);
        n          = 32'(plan_len);
        plan_tms   = 1'b0;
        plan_shift = 1'b0;
        plan_bit   = '0;
        case (plan_st)
            StPostReset, StReset: plan_tms = (s < ResetCycles);
            StIrScan: begin
                if (s >= 4 && s < 4 + IrLength) begin
                    plan_shift = 1'b1;
                    plan_bit   = BitW'(s - 4);
                    plan_tms   = (s == 3 + IrLength);
                end else begin
                    plan_tms = (s < 2) || (s == 4 + IrLength);
                end
            end
            StDrScan: begin
                if (n == 0) begin
                    plan_tms = (s == 0) || (s == 2) || (s == 3);
                end else if (s >= 3 && s < 3 + n) begin
                    plan_shift = 1'b1;
                    plan_bit   = BitW'(s - 3);
                    plan_tms   = (s == 2 + n);
                end else begin
                    plan_tms = (s == 0) || (s == 3 + n);
                end
            end
            default: ;
        endcase
        plan_tdi = plan_shift & plan_data[plan_bit];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StPostReset;
            cyc_q       <= '0;
            slot_q      <= '0;
            bit_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            shift_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        state_q     <= plan_st;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        len_q       <= plan_len;
                        data_q      <= plan_data;
                        rsp_data_q  <= '0;
                        slot_q      <= '0;
                        cyc_q       <= '0;
                        bit_q       <= plan_bit;
                        shift_q     <= plan_shift;
                        tms_q       <= plan_tms;
                        tdi_q       <= plan_tdi;
                        rsp_valid_q <= (plan_st == StResp);
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    // TDO is taken at the end of the first TCK-high cycle of a shift slot.
                    if (shift_q && cyc_q == CycW'(ClkDiv)) begin
                        rsp_data_q[bit_q] <= tdo_i;
                    end
                    if (cyc_q == CycW'(2 * ClkDiv - 1)) begin
                        cyc_q <= '0;
                        tck_q <= 1'b0;
                        if (slot_last) begin
                            tms_q   <= 1'b0;
                            tdi_q   <= 1'b0;
                            shift_q <= 1'b0;
                            if (state_q == StPostReset) begin
                                state_q     <= StIdle;
                                req_ready_q <= 1'b1;
                                busy_q      <= 1'b0;
                            end else begin
                                state_q     <= StResp;
                                rsp_valid_q <= 1'b1;
                            end
                        end else begin
                            slot_q  <= plan_slot;
                            bit_q   <= plan_bit;
                            shift_q <= plan_shift;
                            tms_q   <= plan_tms;
                            tdi_q   <= plan_tdi;
                        end
                    end else begin
                        cyc_q <= cyc_q + CycW'(1);
                        tck_q <= (cyc_q >= CycW'(ClkDiv - 1));
                    end
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = busy_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule

// File: doc/dmi_jtag_master.md
Name: dmi_jtag_master

Overview:
- JTAG initiator (probe side) that drives TCK/TMS/TDI and samples TDO of the DMI JTAG TAP.
- Used in simulation benches and on-chip self-test paths to run IR scans, DR scans and TAP resets, all issued as single transactions.
- Every transaction starts in Run-Test/Idle and ends there.
- Sits between a valid/ready command source and the TAP pins.

Parameters:
- MaxLen, 41: maximum DR scan length in bits (DMI: 7-bit address + 32-bit data + 2-bit op).
- IrLength, 5: IR length of the target TAP.
- ClkDiv, 2: clk_i cycles per TCK half-period. Must be ≥1.
- ResetCycles, 5: TMS=1 slots in a reset sequence. Must be ≥5.

Ports:
- clk_i  in  1  system clock. Single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when req_valid_i and req_ready_o are both high.
- req_op_i  in  2  0=TAP reset, 1=IR scan, 2=DR scan, 3=no-op.
- req_len_i  in  $clog2(MaxLen+1)  DR length. Ignored for other ops.
- req_data_i  in  MaxLen  TDI bits, LSB shifted first.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_data_o  out  MaxLen  captured TDO bits, LSB first captured.
- busy_o  out  1  high whenever not Idle.
- tck_o  out  1  JTAG TCK.
- tms_o  out  1  JTAG TMS.
- tdi_o  out  1  JTAG TDI.
- tdo_i  in  1  JTAG TDO, already synchronous to clk_i.

Behaviour:
- Reset values (applied at the first clk_i edge with rst_i=1, including mid-transaction):
  - tck_o=0, tms_o=1, tdi_o=0
  - req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=1
  - slot and bit counters cleared
- Slot timing:
  - A slot is one TCK period: 2*ClkDiv cycles.
  - Cycles 0..ClkDiv-1: tck_o=0. Cycles ClkDiv..2*ClkDiv-1: tck_o=1.
  - tms_o/tdi_o are registered and change only at the start of a slot, together with TCK falling.
  - tdo_i is sampled at the clk_i edge that ends slot cycle ClkDiv (first high cycle).
- FSM states: PostReset, Idle, Reset, IrScan, DrScan, Resp.
  - After rst_i deasserts, PostReset runs the reset sequence automatically, then enters Idle.
  - Idle: req_ready_o=1, busy_o=0, tck_o=0, tms_o=0, tdi_o=0. TCK is not toggling.
  - On acceptance, the first slot starts the next cycle and the FSM moves to the op state.
- TMS sequence per slot, starting from Run-Test/Idle:
  - Reset: ResetCycles×1, then 0. Total ResetCycles+1 slots.
  - IR: 1,1,0,0, then IrLength shift slots (TMS=0, last slot TMS=1), then 1,0. Total IrLength+6 slots.
  - DR, N=min(req_len_i,MaxLen) ≥1: 1,0,0, then N shift slots (TMS=0, last slot TMS=1), then 1,0. Total N+5 slots.
  - DR, N=0: 1,0,1,1,0. Total 5 slots, nothing shifted.
- Shift slots:
  - In shift slot k, tdi_o = req_data_i[k], latched at acceptance.
  - The sampled tdo_i goes to rsp_data_o[k].
  - Outside shift slots, tdi_o=0.
- Response:
  - rsp_data_o bits at or above the shifted count are 0. Reset and no-op ops return all zeros.
  - The no-op op produces no slots: Resp is entered the cycle after acceptance.
- Latency: acceptance in cycle 0, S slots → rsp_valid_o rises in cycle 1+S*2*ClkDiv.
- Handshake:
  - rsp_valid_o and rsp_data_o are held stable until rsp_ready_i.
  - req_ready_o=0 from acceptance until the cycle after the response handshake; then back to Idle.
  - tck_o stays static (0) in Resp.
  - A request presented while not Idle is neither accepted nor dropped; the source must hold it.
- Clamping: req_len_i above MaxLen is clamped to MaxLen.
- Sizing: shift counter width is sized for max(MaxLen,IrLength).

Test Plan:
- Release rst_i, ClkDiv=2, TAP model with active-low async reset held inactive → tms_o=1 for 20 cycles, then 0 for 4 cycles; req_ready_o=1 in cycle 24; TAP in Run-Test/Idle.
- IR scan, req_data_i=5'h11 → 11 slots; rsp_data_o=41'b00101 (TAP capture pattern); TAP IR then selects DMIACCESS.
- IR scan 5'h01, then DR scan len 32, data 0, TAP IdcodeValue=32'h249511C3 → rsp_data_o[31:0]=32'h249511C3, upper bits 0; DR rsp_valid_o in cycle 1+37*4=149.
- IR scan 5'h1F, then DR len 8, data 8'hA5 → rsp_data_o[7:0]=8'h4A (bypass: one-cycle delay with leading 0).
- DR len 0 → TMS slots 1,0,1,1,0 exactly; rsp_data_o=0. Then hold rsp_ready_i=0 for 10 cycles → rsp_valid_o/rsp_data_o stable, req_ready_o=0, tck_o=0.
- rst_i pulsed during DR shift slot 10 → next cycle tck_o=0, tms_o=1, rsp_valid_o=0; auto reset sequence reruns; a following IDCODE DR read returns 32'h249511C3.
